// File: rtl/phase_seq_pkg.sv
// Shared types for the phase sequencer: state encoding, phase ceiling and a one-hot helper.
package phase_seq_pkg;

  localparam int MAX_PHASES = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    STOPPING = 3'd2,
    HALTED   = 3'd3,
    STEP     = 3'd4
  } seq_state_t;

  function automatic logic [MAX_PHASES-1:0] phase_onehot(input int unsigned idx);
    logic [3:0] bit_idx;
    bit_idx = idx[3:0];
    phase_onehot = '0;
    phase_onehot[bit_idx] = 1'b1;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Multi-flop synchroniser for an active-low board key, followed by a falling-edge
// detector that yields a single-cycle press pulse however long the key is held.
module button_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic sync_reg [STAGES];
  logic level_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic d;
      if (gi == 0) begin : g_first
        assign d = button;
      end else begin : g_chain
        assign d = sync_reg[gi-1];
      end

      // Idle level of the key is high, so a reset never manufactures a press.
      always_ff @(posedge clock) begin
        if (!reset) begin
          sync_reg[gi] <= 1'b1;
        end else begin
          sync_reg[gi] <= d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      level_reg <= 1'b1;
    end else begin
      level_reg <= sync_reg[STAGES-1];
    end
  end

  assign press = level_reg & ~sync_reg[STAGES-1];

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer with run/stop/halt control from the exec key.
// Optional single-step mode is compiled in with the SINGLE_STEP_EN macro.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter  int NUM_PHASES  = 5,
  parameter  int SYNC_STAGES = 2,
  localparam int PHASE_W     = $clog2(NUM_PHASES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  halt,
  input  logic                  stall,
  input  logic                  step_mode,
  output logic                  register_reset,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [PHASE_W-1:0]    phase,
  output logic                  running,
  output logic                  halted
);

  localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] FIRST_EN   = NUM_PHASES'(phase_onehot(0));

  seq_state_t                state_reg;
  logic [PHASE_W-1:0]        phase_reg;
  logic [NUM_PHASES-1:0]     phase_en_reg;
  logic                      running_reg;
  logic                      halted_reg;
  logic                      press;
  logic                      retire;
  seq_state_t                launch_state;

  button_sync #(
    .STAGES(SYNC_STAGES)
  ) u_exec_sync (
    .clock (clock),
    .reset (reset),
    .button(exec),
    .press (press)
  );

`ifdef SINGLE_STEP_EN
  assign launch_state = step_mode ? STEP : RUN;
`else
  logic unused_step_mode;
  assign unused_step_mode = step_mode;
  assign launch_state     = RUN;
`endif

  assign retire = (phase_reg == LAST_PHASE) && !stall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      phase_en_reg <= '0;
      running_reg  <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HALTED: begin
          if (press) begin
            state_reg    <= (state_reg == IDLE) ? launch_state : RUN;
            phase_reg    <= '0;
            phase_en_reg <= FIRST_EN;
            running_reg  <= 1'b1;
            halted_reg   <= 1'b0;
          end
        end
`ifdef SINGLE_STEP_EN
        RUN, STOPPING, STEP: begin
`else
        RUN, STOPPING: begin
`endif
          if (retire) begin
            phase_reg <= '0;
            // Halt outranks a simultaneous press; a press at retire ends the run here.
            if (halt) begin
              state_reg    <= HALTED;
              phase_en_reg <= '0;
              running_reg  <= 1'b0;
              halted_reg   <= 1'b1;
            end else if (state_reg == RUN && !press) begin
              phase_en_reg <= FIRST_EN;
            end else begin
              state_reg    <= IDLE;
              phase_en_reg <= '0;
              running_reg  <= 1'b0;
            end
          end else begin
            if (!stall) begin
              phase_reg    <= phase_reg + 1'b1;
              phase_en_reg <= phase_en_reg << 1;
            end
            if (state_reg == RUN && press) begin
              state_reg   <= STOPPING;
              running_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          phase_reg    <= '0;
          phase_en_reg <= '0;
          running_reg  <= 1'b0;
          halted_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign register_reset = reset;
  assign phase_en       = phase_en_reg;
  assign phase          = phase_reg;
  assign running        = running_reg;
  assign halted         = halted_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an abstract behavioural model.
module tb_phase_sequencer;

  localparam int N = 5;
  localparam int S = 2;
`ifdef SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         exec = 1'b1;
  logic         halt = 1'b0;
  logic         stall = 1'b0;
  logic         step_mode = 1'b0;
  logic         register_reset;
  logic [N-1:0] phase_en;
  logic [2:0]   phase;
  logic         running;
  logic         halted;

  int n_checks = 0;
  int n_fail = 0;

  phase_sequencer #(.NUM_PHASES(N), .SYNC_STAGES(S)) dut (
    .clock         (clock),
    .reset         (reset),
    .exec          (exec),
    .halt          (halt),
    .stall         (stall),
    .step_mode     (step_mode),
    .register_reset(register_reset),
    .phase_en      (phase_en),
    .phase         (phase),
    .running       (running),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = idle, 1 = executing an instruction, 2 = halted.
  // stop/step mark an execution that ends at the next retire.
  int m_mode = 0;
  int m_phase = 0;
  bit m_stop = 0;
  bit m_step = 0;
  bit m_valid = 0;
  bit h [S+1];

  always @(posedge clock) begin
    bit p;
    if (!reset) begin
      m_mode = 0; m_phase = 0; m_stop = 0; m_step = 0; m_valid = 1;
      for (int k = 0; k <= S; k++) h[k] = 1'b1;
    end else begin
      p = h[S] & ~h[S-1];
      if (m_mode == 0 || m_mode == 2) begin
        if (p) begin
          m_step  = (m_mode == 0) && SS && step_mode;
          m_mode  = 1;
          m_phase = 0;
          m_stop  = 0;
        end
      end else if (!stall && m_phase == N-1) begin
        m_phase = 0;
        if (halt) m_mode = 2;
        else if (m_stop || m_step || p) m_mode = 0;
        if (m_mode != 1) begin m_stop = 0; m_step = 0; end
      end else begin
        if (!stall) m_phase++;
        if (p && !m_step) m_stop = 1;
      end
      for (int k = S; k > 0; k--) h[k] = h[k-1];
      h[0] = exec;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("phase_en", 32'(phase_en), (m_mode == 1) ? (32'd1 << m_phase) : 32'd0);
      chk("phase", 32'(phase), 32'(m_phase));
      chk("running", 32'(running), 32'((m_mode == 1) && !m_stop));
      chk("halted", 32'(halted), 32'(m_mode == 2));
      chk("register_reset", 32'(register_reset), 32'(reset));
    end
  end

  task automatic wait_en(input logic [N-1:0] want, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (phase_en !== want && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(phase_en), 32'(want));
  endtask

  task automatic press_pulse();
    exec = 1'b0;
    repeat (3) @(negedge clock);
    exec = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] seq [5];
    logic [N-1:0] prev;
    int starts, count, hold;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_phase_en", 32'(phase_en), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_register_reset", 32'(register_reset), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("rel_register_reset", 32'(register_reset), 32'd1);
    $display("test reset: done");

    // 1: press and watch a full rotation
    exec = 1'b0;
    wait_en(5'b00001, 10, "t1_first_enable");
    exec = 1'b1;
    seq[0] = 5'b00010; seq[1] = 5'b00100; seq[2] = 5'b01000; seq[3] = 5'b10000; seq[4] = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t1_rotation", 32'(phase_en), 32'(seq[i]));
      chk("t1_running", 32'(running), 32'd1);
    end
    $display("test rotate: phase_en=%b running=%0d", phase_en, running);

    // 2: press lands at phase 2, phases 3 and 4 finish, then idle
    wait_en(5'b00001, 10, "t2_sync");
    exec = 1'b0;
    @(negedge clock); chk("t2_p1", 32'(phase_en), 32'h02);
    @(negedge clock); chk("t2_p2", 32'(phase_en), 32'h04);
    @(negedge clock); chk("t2_p3", 32'(phase_en), 32'h08); chk("t2_stopping_run", 32'(running), 32'd0);
    exec = 1'b1;
    @(negedge clock); chk("t2_p4", 32'(phase_en), 32'h10);
    @(negedge clock); chk("t2_idle", 32'(phase_en), 32'h00);
    $display("test stop: phase_en=%b", phase_en);

    // 3: halt at retire, then restart
    exec = 1'b0;
    wait_en(5'b00001, 10, "t3_start");
    exec = 1'b1;
    halt = 1'b1;
    wait_en(5'b10000, 10, "t3_last");
    @(negedge clock);
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_en_off", 32'(phase_en), 32'd0);
    halt = 1'b0;
    exec = 1'b0;
    wait_en(5'b00001, 10, "t3_restart");
    chk("t3_phase0", 32'(phase), 32'd0);
    chk("t3_unhalted", 32'(halted), 32'd0);
    exec = 1'b1;
    $display("test halt: halted=%0d phase=%0d", halted, phase);

    // 4: stall holds phase 1 for four cycles total
    wait_en(5'b00010, 10, "t4_phase1");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t4_hold", 32'(phase_en), 32'h02);
    end
    stall = 1'b0;
    @(negedge clock);
    chk("t4_resume", 32'(phase_en), 32'h04);
    press_pulse();
    wait_en(5'b00000, 20, "t4_stop");
    $display("test stall: phase_en=%b", phase_en);

    // 5: long hold gives one press; press and halt retire coincide
    @(negedge clock);
    starts = 0;
    prev = phase_en;
    exec = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (i == 20) exec = 1'b1;
      if (prev == '0 && phase_en != '0) starts++;
      prev = phase_en;
    end
    chk("t5_one_press", 32'(starts), 32'd1);
    chk("t5_still_running", 32'(running), 32'd1);
    wait_en(5'b00100, 10, "t5_phase2");
    halt = 1'b1;
    exec = 1'b0;
    repeat (3) @(negedge clock);
    chk("t5_halt_wins", 32'(halted), 32'd1);
    halt = 1'b0;
    repeat (5) @(negedge clock);
    exec = 1'b1;
    repeat (3) @(negedge clock);
    chk("t5_press_dropped", 32'(halted), 32'd1);
    press_pulse();
    press_pulse();
    wait_en(5'b00000, 20, "t5_stop");
    $display("test press: starts=%0d", starts);

`ifdef SINGLE_STEP_EN
    // 6: single instruction in step mode, then reset mid-instruction
    step_mode = 1'b1;
    repeat (2) @(negedge clock);
    count = 0;
    exec = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (i == 3) exec = 1'b1;
      if (phase_en != '0) count++;
    end
    chk("t6_five_enables", 32'(count), 32'd5);
    chk("t6_idle", 32'(phase_en), 32'd0);
    exec = 1'b0;
    wait_en(5'b01000, 10, "t6_phase3");
    reset = 1'b0;
    exec = 1'b1;
    @(negedge clock);
    chk("t6_rst_en", 32'(phase_en), 32'd0);
    chk("t6_rst_phase", 32'(phase), 32'd0);
    chk("t6_rst_running", 32'(running), 32'd0);
    chk("t6_rst_halted", 32'(halted), 32'd0);
    reset = 1'b1;
    step_mode = 1'b0;
    $display("test step: enables=%0d", count);
`else
    count = 0;
`endif

    // Randomized traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (hold == 0) begin
        exec = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      halt      = ($urandom_range(0, 3) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      step_mode = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 299) != 0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    $display("test random: 3000 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
